// File: rtl/i2s_tdm_tx.sv
// I2S / TDM serial transmitter with a single-entry frame holding buffer.
// Define I2S_TDM_TX_UNDERRUN_HOLD_EN to repeat the last loaded frame on underrun (zeros otherwise).
module i2s_tdm_tx #(
   parameter int unsigned SAMPLE_WIDTH = 16,
   parameter int unsigned CHANNELS     = 2,
   parameter int unsigned CLK_DIV      = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [CHANNELS*SAMPLE_WIDTH-1:0] sample_data,
   input  logic                             sample_valid,
   output logic                             sample_ready,
   output logic                             underrun,
   input  logic                             underrun_clr,
   output logic                             I2S_BCK,
   output logic                             I2S_LRCK,
   output logic                             I2S_DATA
);

   localparam int unsigned FRAME_BITS = CHANNELS * SAMPLE_WIDTH;
   localparam int unsigned HALF_BITS  = FRAME_BITS / 2;
   localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BITS);

   logic [DIV_W-1:0]      div_q, div_d;
   logic                  bck_q, bck_d;
   logic                  lrck_q, lrck_d;
   logic                  data_q, data_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [FRAME_BITS-1:0] buf_q, buf_d;
   logic                  full_q, full_d;
   logic                  ready_q, ready_d;
   logic                  underrun_q, underrun_d;

   logic                  div_wrap;
   logic                  bck_fall;
   logic                  frame_load;
   logic                  xfer;
   logic [FRAME_BITS-1:0] uf_frame;
   logic [FRAME_BITS-1:0] load_raw;
   logic [FRAME_BITS-1:0] load_ser;

`ifdef I2S_TDM_TX_UNDERRUN_HOLD_EN
   logic [FRAME_BITS-1:0] last_q, last_d;
   assign uf_frame = last_q;
`else
   assign uf_frame = '0;
`endif

   assign div_wrap   = (div_q == DIV_LAST);
   assign bck_fall   = div_wrap & bck_q;
   assign frame_load = bck_fall & (cnt_q == CNT_LAST);
   assign xfer       = sample_valid & ready_q;
   assign load_raw   = full_q ? buf_q : uf_frame;

   // Reorder the port layout (channel 0 in the LSB slot) into transmit order (channel 0 first).
   for (genvar c = 0; c < CHANNELS; c++) begin : g_slot
      assign load_ser[FRAME_BITS-1-c*SAMPLE_WIDTH -: SAMPLE_WIDTH] =
         load_raw[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
   end

   always_comb begin
      div_d      = div_q;
      bck_d      = bck_q;
      lrck_d     = lrck_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      buf_d      = buf_q;
      full_d     = full_q;
      ready_d    = ready_q;
      underrun_d = underrun_q;
`ifdef I2S_TDM_TX_UNDERRUN_HOLD_EN
      last_d     = last_q;
`endif

      div_d = div_wrap ? '0 : div_q + DIV_W'(1);
      if (div_wrap) begin
         bck_d = ~bck_q;
      end

      // DATA lags the shift register by one bit time, giving the I2S one-bit delay
      // relative to LRCK; the slot-0 bit is the LSB left over from the previous frame.
      if (bck_fall) begin
         data_d = shift_q[FRAME_BITS-1];
         if (frame_load) begin
            cnt_d   = '0;
            shift_d = load_ser;
`ifdef I2S_TDM_TX_UNDERRUN_HOLD_EN
            last_d  = load_raw;
`endif
         end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
         end
         lrck_d = (cnt_d >= CNT_HALF);
      end

      // A load samples the buffer state from before any same-cycle transfer.
      if (frame_load) begin
         full_d = xfer;
      end else if (xfer) begin
         full_d = 1'b1;
      end
      if (xfer) begin
         buf_d = sample_data;
      end
      ready_d = ~full_d;

      if (frame_load && !full_q) begin
         underrun_d = 1'b1;
      end else if (underrun_clr) begin
         underrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q      <= '0;
         bck_q      <= 1'b0;
         lrck_q     <= 1'b0;
         data_q     <= 1'b0;
         cnt_q      <= '0;
         shift_q    <= '0;
         buf_q      <= '0;
         full_q     <= 1'b0;
         ready_q    <= 1'b0;
         underrun_q <= 1'b0;
`ifdef I2S_TDM_TX_UNDERRUN_HOLD_EN
         last_q     <= '0;
`endif
      end else begin
         div_q      <= div_d;
         bck_q      <= bck_d;
         lrck_q     <= lrck_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         buf_q      <= buf_d;
         full_q     <= full_d;
         ready_q    <= ready_d;
         underrun_q <= underrun_d;
`ifdef I2S_TDM_TX_UNDERRUN_HOLD_EN
         last_q     <= last_d;
`endif
      end
   end

   assign sample_ready = ready_q;
   assign underrun     = underrun_q;
   assign I2S_BCK      = bck_q;
   assign I2S_LRCK     = lrck_q;
   assign I2S_DATA     = data_q;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Directed bench for i2s_tdm_tx: a 2x16 instance (CLK_DIV=4) and a 4x24 TDM instance (CLK_DIV=2).
module tb_i2s_tdm_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [31:0] data0;
   logic        valid0, clr0;
   logic        ready0, ur0, bck0, lr0, dat0;
   logic [95:0] data4;
   logic        valid4, clr4;
   logic        ready4, ur4, bck4, lr4, dat4;

   i2s_tdm_tx #(.SAMPLE_WIDTH(16), .CHANNELS(2), .CLK_DIV(4)) u_dut0 (
      .clk(clk), .reset(reset), .sample_data(data0), .sample_valid(valid0),
      .sample_ready(ready0), .underrun(ur0), .underrun_clr(clr0),
      .I2S_BCK(bck0), .I2S_LRCK(lr0), .I2S_DATA(dat0));

   i2s_tdm_tx #(.SAMPLE_WIDTH(24), .CHANNELS(4), .CLK_DIV(2)) u_dut4 (
      .clk(clk), .reset(reset), .sample_data(data4), .sample_valid(valid4),
      .sample_ready(ready4), .underrun(ur4), .underrun_clr(clr4),
      .I2S_BCK(bck4), .I2S_LRCK(lr4), .I2S_DATA(dat4));

   int checks = 0;
   int errors = 0;
   int cyc;
   int n0, n4, xfers0;
   logic bck0_prev, bck4_prev;
   logic d0_dat [512];
   logic d0_lr  [512];
   logic d4_dat [512];
   logic d4_lr  [512];

   // clk edges since reset release
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // Capture DATA/LRCK at each BCK rising edge; count handshakes about to complete.
   always @(negedge clk) begin
      if (reset) begin
         n0 = 0; n4 = 0; xfers0 = 0;
         bck0_prev = 1'b0; bck4_prev = 1'b0;
      end else begin
         if (bck0 && !bck0_prev && n0 < 512) begin
            d0_dat[n0] = dat0; d0_lr[n0] = lr0; n0++;
         end
         if (bck4 && !bck4_prev && n4 < 512) begin
            d4_dat[n4] = dat4; d4_lr[n4] = lr4; n4++;
         end
         bck0_prev = bck0;
         bck4_prev = bck4;
         if (valid0 && ready0) xfers0++;
      end
   end

   function automatic logic [31:0] f0(input int f, input bit lr);
      logic [31:0] v;
      for (int j = 0; j < 32; j++) v[31-j] = lr ? d0_lr[32*f+j] : d0_dat[32*f+j];
      return v;
   endfunction

   function automatic logic [95:0] f4(input int f, input bit lr);
      logic [95:0] v;
      for (int j = 0; j < 96; j++) v[95-j] = lr ? d4_lr[96*f+j] : d4_dat[96*f+j];
      return v;
   endfunction

   task automatic wait_cyc(input int t);
      int guard = 0;
      while (cyc < t && guard < 20000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (cyc < t) begin
         checks++; errors++;
         $display("FAIL wait_cyc: reached %0d, required %0d", cyc, t);
      end
   endtask

   task automatic wait_rises0(input int n);
      int guard = 0;
      while (n0 < n && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (n0 < n) begin
         checks++; errors++;
         $display("FAIL wait_rises0: got %0d BCK rises, required %0d", n0, n);
      end
   endtask

   task automatic wait_rises4(input int n);
      int guard = 0;
      while (n4 < n && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (n4 < n) begin
         checks++; errors++;
         $display("FAIL wait_rises4: got %0d BCK rises, required %0d", n4, n);
      end
   endtask

   task automatic do_reset;
      reset = 1'b1; valid0 = 1'b0; valid4 = 1'b0; clr0 = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset;
      int k;
      reset = 1'b1; valid0 = 1'b0; clr0 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bck0, lr0, dat0, ur0, ready0} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 00000", {bck0, lr0, dat0, ur0, ready0});
      end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ready0 !== 1'b1) begin
         errors++; $display("FAIL ready_after_release: got %b expected 1", ready0);
      end
      k = 1;
      while (bck0 !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
      checks++;
      if (k !== 4) begin
         errors++; $display("FAIL first_bck_rise: got %0d clk expected 4", k);
      end
      k = 0;
      while (bck0 === 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
      while (bck0 === 1'b0 && k < 50) begin @(posedge clk); #1; k++; end
      checks++;
      if (k !== 8) begin
         errors++; $display("FAIL bck_period: got %0d clk expected 8", k);
      end
      k = 0;
      while (lr0 !== 1'b1 && k < 2000) begin @(posedge clk); #1; k++; end
      k = 0;
      while (lr0 === 1'b1 && k < 2000) begin @(posedge clk); #1; k++; end
      while (lr0 === 1'b0 && k < 2000) begin @(posedge clk); #1; k++; end
      checks++;
      if (k !== 256) begin
         errors++; $display("FAIL lrck_period: got %0d clk expected 256", k);
      end
   endtask

   task automatic test_stream;
      logic [31:0] exp_d [4];
      exp_d = '{32'h0000_0000, 32'h091A_4000, 32'h891A_4000, 32'h891A_4000};
      do_reset();
      data0 = {16'h8001, 16'h1234};
      valid0 = 1'b1;
      wait_cyc(1000);
      checks++;
      if (xfers0 !== 4) begin
         errors++; $display("FAIL stream_one_xfer_per_frame: got %0d expected 4", xfers0);
      end
      wait_rises0(128);
      for (int f = 0; f < 4; f++) begin
         checks++;
         if (f0(f, 1'b0) !== exp_d[f]) begin
            errors++; $display("FAIL stream_data_f%0d: got %h expected %h", f, f0(f, 1'b0), exp_d[f]);
         end
      end
      for (int f = 0; f < 2; f++) begin
         checks++;
         if (f0(f, 1'b1) !== 32'h0000_FFFF) begin
            errors++; $display("FAIL stream_lrck_f%0d: got %h expected 0000ffff", f, f0(f, 1'b1));
         end
      end
      checks++;
      if (ur0 !== 1'b0) begin
         errors++; $display("FAIL stream_no_underrun: got %b expected 0", ur0);
      end
      valid0 = 1'b0;
   endtask

   task automatic test_underrun;
      logic [31:0] exp_f2;
`ifdef I2S_TDM_TX_UNDERRUN_HOLD_EN
      exp_f2 = 32'h8787_D2D2;
`else
      exp_f2 = 32'h8000_0000;
`endif
      do_reset();
      data0 = {16'hA5A5, 16'h0F0F};
      wait_cyc(1); valid0 = 1'b1;
      wait_cyc(2); valid0 = 1'b0;
      checks++;
      if (xfers0 !== 1) begin
         errors++; $display("FAIL uf_single_xfer: got %0d expected 1", xfers0);
      end
      wait_cyc(500);
      checks++;
      if (ur0 !== 1'b0) begin
         errors++; $display("FAIL uf_before: got %b expected 0", ur0);
      end
      wait_cyc(513);
      checks++;
      if (ur0 !== 1'b1) begin
         errors++; $display("FAIL uf_set: got %b expected 1", ur0);
      end
      wait_cyc(600); clr0 = 1'b1;
      wait_cyc(601); clr0 = 1'b0;
      checks++;
      if (ur0 !== 1'b0) begin
         errors++; $display("FAIL uf_clr: got %b expected 0", ur0);
      end
      wait_cyc(760); clr0 = 1'b1;
      wait_cyc(768);
      checks++;
      if (ur0 !== 1'b1) begin
         errors++; $display("FAIL uf_set_wins: got %b expected 1", ur0);
      end
      clr0 = 1'b0;
      wait_rises0(96);
      checks++;
      if (f0(1, 1'b0) !== 32'h0787_D2D2) begin
         errors++; $display("FAIL uf_frame_a: got %h expected 0787d2d2", f0(1, 1'b0));
      end
      checks++;
      if (f0(2, 1'b0) !== exp_f2) begin
         errors++; $display("FAIL uf_frame_fill: got %h expected %h", f0(2, 1'b0), exp_f2);
      end
   endtask

   task automatic test_back_to_back;
      do_reset();
      data0 = {16'h1357, 16'h2468};
      wait_cyc(511); valid0 = 1'b1;
      wait_cyc(512); valid0 = 1'b0;
      checks++;
      if (xfers0 !== 1) begin
         errors++; $display("FAIL sc_xfer_count: got %0d expected 1", xfers0);
      end
      checks++;
      if (ready0 !== 1'b0) begin
         errors++; $display("FAIL sc_ready_low: got %b expected 0", ready0);
      end
      checks++;
      if (ur0 !== 1'b1) begin
         errors++; $display("FAIL sc_underrun: got %b expected 1", ur0);
      end
      wait_rises0(128);
      checks++;
      if (f0(2, 1'b0) !== 32'h0000_0000) begin
         errors++; $display("FAIL sc_frame_empty: got %h expected 00000000", f0(2, 1'b0));
      end
      checks++;
      if (f0(3, 1'b0) !== 32'h1234_09AB) begin
         errors++; $display("FAIL sc_frame_next: got %h expected 123409ab", f0(3, 1'b0));
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      data0 = {16'hA5A5, 16'h0F0F};
      valid0 = 1'b1;
      wait_rises0(43);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({bck0, lr0, dat0, ur0, ready0} !== 5'b0) begin
         errors++;
         $display("FAIL rm_async_zero: got %b expected 00000", {bck0, lr0, dat0, ur0, ready0});
      end
      valid0 = 1'b0;
      data0 = {16'h8001, 16'h1234};
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      valid0 = 1'b1;
      wait_rises0(64);
      checks++;
      if (f0(0, 1'b0) !== 32'h0000_0000) begin
         errors++; $display("FAIL rm_f0_clean: got %h expected 00000000", f0(0, 1'b0));
      end
      checks++;
      if (f0(1, 1'b0) !== 32'h091A_4000) begin
         errors++; $display("FAIL rm_f1_new: got %h expected 091a4000", f0(1, 1'b0));
      end
      valid0 = 1'b0;
   endtask

   task automatic test_tdm4;
      logic [95:0] stream, exp_d, exp_lr;
      stream = {24'h000001, 24'h000002, 24'h000003, 24'h000004};
      exp_d  = {1'b0, stream[95:1]};
      exp_lr = {48'h0, {48{1'b1}}};
      do_reset();
      valid4 = 1'b1;
      wait_rises4(288);
      for (int f = 1; f < 3; f++) begin
         checks++;
         if (f4(f, 1'b0) !== exp_d) begin
            errors++; $display("FAIL tdm_data_f%0d: got %h expected %h", f, f4(f, 1'b0), exp_d);
         end
         checks++;
         if (f4(f, 1'b1) !== exp_lr) begin
            errors++; $display("FAIL tdm_lrck_f%0d: got %h expected %h", f, f4(f, 1'b1), exp_lr);
         end
      end
      checks++;
      if (d4_dat[96+24] !== 1'b1) begin
         errors++; $display("FAIL tdm_ch0_lsb: got %b expected 1", d4_dat[96+24]);
      end
      checks++;
      if (ur4 !== 1'b0) begin
         errors++; $display("FAIL tdm_no_underrun: got %b expected 0", ur4);
      end
      valid4 = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      valid0 = 1'b0; clr0 = 1'b0; data0 = '0;
      valid4 = 1'b0; clr4 = 1'b0;
      data4  = {24'h000004, 24'h000003, 24'h000002, 24'h000001};
      test_reset();
      test_stream();
      test_underrun();
      test_back_to_back();
      test_reset_mid();
      test_tdm4();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
